// File: rtl/ss_seq.sv
// Save-state sequencer: copies mapper registers plus the mapper index into a byte buffer,
// and restores them after checking that the buffered index matches this mapper.
module ss_seq #(
   parameter int         REG_CNT  = 2,
   parameter int         IDX_ADDR = 127,
   parameter logic [7:0] MAP_IDX  = 8'd0,
   parameter int         TMO      = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       save_req,
   input  logic       load_req,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ss_act,
   output logic       ss_we,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdat,
   input  logic [7:0] mem_rdat,
   input  logic       mem_ack
);
   typedef enum logic [2:0] {IDLE, S_RD, S_WR, L_IDX, L_RD, L_WR, FIN, ERR} state_t;

   localparam logic [7:0] LAST     = 8'(REG_CNT - 1);
   localparam logic [7:0] IDX_SLOT = 8'(REG_CNT);
   localparam logic [7:0] IDX_SS   = 8'(IDX_ADDR);
   localparam logic [7:0] TMO_CNT  = 8'(TMO);

   state_t     state, state_nxt;
   logic [7:0] a, data, wcnt;
   logic       ack, tmo_hit;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      state_nxt = state;
      ack       = mem_req && mem_ack;
      tmo_hit   = mem_req && !mem_ack && (wcnt + 8'd1 >= TMO_CNT);
      case (state)
         IDLE: begin
            if (save_req)      state_nxt = S_RD;
            else if (load_req) state_nxt = L_IDX;
         end
         S_RD: state_nxt = S_WR;
         S_WR: begin
            if (tmo_hit)  state_nxt = ERR;
            else if (ack) state_nxt = (a == IDX_SLOT) ? FIN : S_RD;
         end
         L_IDX: begin
            if (tmo_hit)  state_nxt = ERR;
            else if (ack) state_nxt = (mem_rdat == MAP_IDX) ? L_RD : ERR;
         end
         L_RD: begin
            if (tmo_hit)  state_nxt = ERR;
            else if (ack) state_nxt = L_WR;
         end
         L_WR:    state_nxt = (a == LAST) ? FIN : L_RD;
         default: state_nxt = IDLE;
      endcase
   end

   // a == IDX_SLOT marks the extra save pass that stores the mapper index.
   // NOTE: sequential state uses non-blocking assignments only; the async reset clears all of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a        <= 8'd0;
         data     <= 8'd0;
         wcnt     <= 8'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         ss_act   <= 1'b0;
         ss_we    <= 1'b0;
         ss_addr  <= 8'd0;
         ss_wdat  <= 8'd0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= 8'd0;
         mem_wdat <= 8'd0;
      end else begin
         state  <= state_nxt;
         busy   <= (state_nxt != IDLE);
         ss_act <= !(state_nxt inside {IDLE, FIN, ERR});
         done   <= (state_nxt == FIN);
         ss_we  <= 1'b0;
         if (state_nxt == ERR)    err     <= 1'b1;
         if (mem_req && !mem_ack) wcnt    <= wcnt + 8'd1;
         if (ack || tmo_hit)      mem_req <= 1'b0;

         // A memory state issues its request one cycle after entry, leaving a gap after each ack.
         case (state)
            IDLE: begin
               if (save_req || load_req) begin
                  err <= 1'b0;
                  a   <= 8'd0;
               end
               if (save_req) ss_addr <= 8'd0;
            end
            S_RD: data <= ss_rdat;
            S_WR: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  wcnt     <= 8'd0;
                  mem_we   <= 1'b1;
                  mem_addr <= a;
                  mem_wdat <= data;
               end else if (ack && a != IDX_SLOT) begin
                  a       <= a + 8'd1;
                  ss_addr <= (a == LAST) ? IDX_SS : a + 8'd1;
               end
            end
            L_IDX: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  wcnt     <= 8'd0;
                  mem_we   <= 1'b0;
                  mem_addr <= IDX_SLOT;
               end else if (ack) begin
                  a <= 8'd0;
               end
            end
            L_RD: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  wcnt     <= 8'd0;
                  mem_we   <= 1'b0;
                  mem_addr <= a;
               end else if (ack) begin
                  data    <= mem_rdat;
                  ss_addr <= a;
                  ss_wdat <= mem_rdat;
                  ss_we   <= 1'b1;
               end
            end
            L_WR: if (a != LAST) a <= a + 8'd1;
            default: ;
         endcase
      end
   end
endmodule
